// File: rtl/pi64_error_sequencer_pkg.sv
// Shared constants and types for the 64-bit PI error sequencer.
// Lead time is shared with the downstream PI stage.
package pi64_error_sequencer_pkg;

  localparam int PI_LEAD_CLK = 15;
  localparam int ADD_SUB_LAT = 7;

  localparam logic OP_ADD   = 1'b1;
  localparam logic OP_SUB   = 1'b0;
  localparam logic ENA_MATH = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_LEADW
  } seq_state_e;

endpackage

// File: rtl/pi64_error_sequencer_add_sub.sv
// Pipelined IEEE-754 double add/sub (truncating, denormal results flush
// to zero). NaN/Inf operands pass through unmodified.
module pi64_error_sequencer_add_sub
  import pi64_error_sequencer_pkg::*;
#(
  parameter int LAT = ADD_SUB_LAT
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        aclr,
  input  logic        add_sub,
  input  logic [63:0] dataa,
  input  logic [63:0] datab,
  output logic [63:0] result
);

  function automatic logic [63:0] fp_add(
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [63:0] hi, lo, gl, gs, sum;
    logic [10:0] efl, efs;
    int d, p, e;
    if (a[62:52] == 11'h7FF) begin
      if (a[51:0] != '0) return a;
      if (b[62:52] == 11'h7FF && b[51:0] == '0 && a[63] != b[63])
        return 64'h7FF8000000000000;
      return a;
    end
    if (b[62:52] == 11'h7FF) return b;
    if (a[62:0] >= b[62:0]) begin
      hi = a;
      lo = b;
    end else begin
      hi = b;
      lo = a;
    end
    efl = (hi[62:52] == '0) ? 11'd1 : hi[62:52];
    efs = (lo[62:52] == '0) ? 11'd1 : lo[62:52];
    gl  = {1'b0, hi[62:52] != '0, hi[51:0], 10'b0};
    gs  = {1'b0, lo[62:52] != '0, lo[51:0], 10'b0};
    d   = int'(efl) - int'(efs);
    gs  = (d > 63) ? '0 : gs >> d;
    sum = (hi[63] == lo[63]) ? gl + gs : gl - gs;
    if (sum == '0) return '0;
    p = 0;
    for (int i = 0; i < 64; i++)
      if (sum[i]) p = i;
    e = int'(efl) + p - 62;
    if (e >= 2047) return {hi[63], 11'h7FF, 52'b0};
    if (e <= 0) return {hi[63], 63'b0};
    return {hi[63], 11'(e), 52'((sum << (63 - p)) >> 11)};
  endfunction

  logic [63:0] pipe [LAT];
  logic [63:0] b_eff;

  assign b_eff  = {datab[63] ^ (add_sub != OP_ADD), datab[62:0]};
  assign result = pipe[LAT-1];

  always_ff @(posedge clk) begin
    if (aclr) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (clk_en) begin
      pipe[0] <= fp_add(dataa, b_eff);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

endmodule

// File: rtl/pi64_error_sequencer.sv
// Forms err = ref - meas per step and drives the PI done_read_x / sta
// handshake, with overrun flag and issued-step counter.
module pi64_error_sequencer
  import pi64_error_sequencer_pkg::*;
#(
  parameter int ADD_LAT  = ADD_SUB_LAT,
  parameter int LEAD     = PI_LEAD_CLK,
  parameter bit SUB_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_user,
  input  logic        sta_in,
  input  logic [63:0] ref_val,
  input  logic [63:0] meas,
  output logic [63:0] x,
  output logic        done_read_x,
  output logic        sta,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] step_cnt
);

  localparam int CW = $clog2(LEAD + 1);
  localparam logic [CW-1:0] LAT_C  = CW'(ADD_LAT);
  localparam logic [CW-1:0] LEAD_C = CW'(LEAD);
  localparam logic [CW-1:0] FIRE_C = CW'(LEAD - 1);

  if (LEAD < ADD_LAT + 1) begin : g_lead_chk
    $error("LEAD must be >= ADD_LAT+1");
  end

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, load_x, fire;
  logic [63:0]   opa_q, opb_q, sum;

  pi64_error_sequencer_add_sub #(
    .LAT(ADD_LAT)
  ) u_add (
    .clk    (clk),
    .clk_en (ENA_MATH),
    .aclr   (1'b0),
    .add_sub(OP_SUB),
    .dataa  (opa_q),
    .datab  (opb_q),
    .result (sum)
  );

  assign busy = (state_q != S_IDLE);
  // cnt_q is 0 in the cycle after acceptance; sta is registered one early
  assign fire = busy && (cnt_q == FIRE_C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    load_x  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sta_in) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT_C) begin
          load_x  = 1'b1;
          state_d = S_LEADW;
        end
      end
      S_LEADW: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LEAD_C) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      x           <= '0;
      done_read_x <= 1'b0;
      sta         <= 1'b0;
      overrun     <= 1'b0;
      step_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_read_x <= accept;
      sta         <= fire;
      if (accept) begin
        opa_q <= SUB_MODE ? meas : ref_val;
        opb_q <= SUB_MODE ? ref_val : meas;
      end
      if (load_x) x <= sum;
      if (rst_user) begin
        overrun  <= 1'b0;
        step_cnt <= '0;
      end else begin
        if (sta_in && busy) overrun <= 1'b1;
        if (fire) step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pi64_error_sequencer.sv
// Directed bench for pi64_error_sequencer: timing, overrun, reset,
// step period, user clear and counter wrap.
module tb_pi64_error_sequencer;

  localparam logic [63:0] D_0   = 64'h0000000000000000;
  localparam logic [63:0] D_025 = 64'h3FD0000000000000;
  localparam logic [63:0] D_05  = 64'h3FE0000000000000;
  localparam logic [63:0] D_075 = 64'h3FE8000000000000;
  localparam logic [63:0] D_N75 = 64'hBFE8000000000000;
  localparam logic [63:0] D_1   = 64'h3FF0000000000000;
  localparam logic [63:0] D_15  = 64'h3FF8000000000000;
  localparam logic [63:0] D_2   = 64'h4000000000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_user = 1'b0;
  logic        sta_in = 1'b0;
  logic [63:0] ref_val = '0;
  logic [63:0] meas = '0;

  logic [63:0] x0, x1;
  logic        done0, done1, sta0, sta1, busy0, busy1, ovr0, ovr1;
  logic [15:0] cnt0, cnt1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pi64_error_sequencer #(.SUB_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rst_user(rst_user), .sta_in(sta_in),
    .ref_val(ref_val), .meas(meas), .x(x0), .done_read_x(done0),
    .sta(sta0), .busy(busy0), .overrun(ovr0), .step_cnt(cnt0)
  );

  pi64_error_sequencer #(.SUB_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rst_user(rst_user), .sta_in(sta_in),
    .ref_val(ref_val), .meas(meas), .x(x1), .done_read_x(done1),
    .sta(sta1), .busy(busy1), .overrun(ovr1), .step_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  // drive a strobe in the current cycle T; returns in cycle T+1
  task automatic strobe(input logic [63:0] r, input logic [63:0] m);
    ref_val = r;
    meas    = m;
    sta_in  = 1'b1;
    tick();
    sta_in  = 1'b0;
  endtask

  // samples sta over cycles T+k0..T+k1; reports count and first hit
  task automatic watch(input int k0, input int k1,
                       output int n, output int first);
    n = 0;
    first = -1;
    for (int k = k0; k <= k1; k++) begin
      if (sta0) begin
        n++;
        if (first < 0) first = k;
      end
      tick();
    end
  endtask

  int n, first;

  initial begin
    // reset together with a strobe: strobe is dropped
    sta_in = 1'b1;
    tick();
    sta_in = 1'b0;
    check("rst_x", x0, D_0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_sta", 64'(sta0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_ovr", 64'(ovr0), 64'd0);
    check("rst_cnt", 64'(cnt0), 64'd0);
    rst = 1'b1;
    tick();
    check("rst_drop", 64'(busy0), 64'd0);

    // basic step, both subtraction modes
    strobe(D_1, D_025);
    check("t1_done", 64'(done0), 64'd1);
    check("t1_busy", 64'(busy0), 64'd1);
    adv(1);
    check("t1_done_pulse", 64'(done0), 64'd0);
    adv(6);
    check("t1_x_old", x0, D_0);
    adv(1);
    check("t1_x", x0, D_075);
    check("t2_x_swap", x1, D_N75);
    adv(6);
    check("t1_sta_early", 64'(sta0), 64'd0);
    adv(1);
    check("t1_sta", 64'(sta0), 64'd1);
    check("t2_sta", 64'(sta1), 64'd1);
    check("t1_cnt", 64'(cnt0), 64'd1);
    adv(1);
    check("t1_sta_off", 64'(sta0), 64'd0);
    check("t1_idle", 64'(busy0), 64'd0);

    // second strobe while busy
    strobe(D_2, D_05);
    adv(4);
    strobe(D_1, D_1);
    check("t3_ovr", 64'(ovr0), 64'd1);
    check("t3_no_done", 64'(done0), 64'd0);
    watch(6, 40, n, first);
    check("t3_nsta", 64'(n), 64'd1);
    check("t3_sta_at", 64'(first), 64'd16);
    check("t3_x", x0, D_15);
    check("t3_cnt", 64'(cnt0), 64'd2);

    // reset mid-step aborts it
    strobe(D_1, D_025);
    adv(7);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("t4_x", x0, D_0);
    check("t4_done", 64'(done0), 64'd0);
    check("t4_sta", 64'(sta0), 64'd0);
    check("t4_busy", 64'(busy0), 64'd0);
    check("t4_ovr", 64'(ovr0), 64'd0);
    check("t4_cnt", 64'(cnt0), 64'd0);
    adv(1);
    strobe(D_1, D_05);
    watch(11, 30, n, first);
    check("t4_nsta", 64'(n), 64'd1);
    check("t4_sta_at", 64'(first), 64'd26);
    check("t4_x_new", x0, D_05);

    // back-to-back steps at the minimum period
    rst_user = 1'b1;
    tick();
    rst_user = 1'b0;
    check("t5_clr_cnt", 64'(cnt0), 64'd0);
    strobe(D_1, D_0);
    adv(8);
    check("t5_x1", x0, D_1);
    adv(8);
    strobe(D_1, D_05);
    check("t5_x1_hold_done", x0, D_1);
    adv(7);
    check("t5_x1_hold_calc", x0, D_1);
    adv(1);
    check("t5_x2", x0, D_05);
    adv(8);
    strobe(D_1, D_1);
    check("t5_accept3", 64'(done0), 64'd1);
    adv(8);
    check("t5_x3", x0, D_0);
    adv(7);
    check("t5_sta3", 64'(sta0), 64'd1);
    check("t5_cnt", 64'(cnt0), 64'd3);
    adv(1);
    check("t5_ovr", 64'(ovr0), 64'd0);

    // strobe during the sta cycle is an overrun
    strobe(D_2, D_05);
    adv(16);
    strobe(D_1, D_025);
    adv(15);
    check("t6_sta", 64'(sta0), 64'd1);
    sta_in = 1'b1;
    tick();
    sta_in = 1'b0;
    check("t6_ovr", 64'(ovr0), 64'd1);
    check("t6_cnt", 64'(cnt0), 64'd5);
    check("t6_ignored", 64'(done0), 64'd0);
    rst_user = 1'b1;
    tick();
    rst_user = 1'b0;
    check("t6_clr_ovr", 64'(ovr0), 64'd0);
    check("t6_clr_cnt", 64'(cnt0), 64'd0);
    check("t6_x_keep", x0, D_075);

    // counter wrap
    force dut0.step_cnt = 16'hFFFF;
    tick();
    release dut0.step_cnt;
    strobe(D_1, D_0);
    adv(15);
    check("t6_wrap_sta", 64'(sta0), 64'd1);
    check("t6_wrap", 64'(cnt0), 64'd0);
    adv(1);

    // clear coincident with increment: clear wins
    strobe(D_1, D_0);
    adv(14);
    rst_user = 1'b1;
    tick();
    rst_user = 1'b0;
    check("t6_clr_sta", 64'(sta0), 64'd1);
    check("t6_clr_wins", 64'(cnt0), 64'd0);
    adv(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
